uart_wb_bridge: RTL

- Serial debug bridge: receives 8N1 command frames from an external host on a UART pin and executes single 32-bit Wishbone master transactions.
- Acts as the initiator end of the user-area Wishbone bus; it is the counterpart to the UART slave peripherals.
- Contains its own 8N1 receiver, 8N1 transmitter, command parser FSM and Wishbone master.
- Lets a host poke and peek any Wishbone address (including the UART CSRs) without the CPU.

---
 rtl/uart_wb_bridge.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: serial debug bridge. A host sends 8N1 command frames on rx;
// the bridge decodes them, runs one 32-bit Wishbone master transfer and
// sends the response bytes back on tx.
//   'W' A3 A2 A1 A0 D3 D2 D1 D0 -> write, reply 'K'
//   'R' A3 A2 A1 A0             -> read,  reply D3 D2 D1 D0
//   other first byte            -> reply '?'
//   Wishbone timeout            -> reply 'E'
module uart_wb_bridge #(
  parameter int CLK_DIV    = 4167,
  parameter int WB_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] DIV_M2  = 16'(CLK_DIV - 2);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] TMO_M1  = 16'(WB_TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WB, S_RESP} state_t;

  // ---------------- RX engine ----------------
  logic        rx_meta, rx_sync, rx_prev;
  logic        rx_fall;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        byte_valid;
  logic        frame_err;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Frame receiver: mid-bit sampling, glitch rejection, stop-bit validation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_sync, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- TX engine ----------------
  logic        tx_load;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_sh;
  logic        tx_done;
  logic        tx_near;

  // tx_near fires one cycle before the stop bit ends so the parser's
  // registered load lands exactly on the last stop cycle: no idle gap.
  assign tx_done = tx_active && (tx_bit == 4'd9) && (tx_cnt == DIV_M1);
  assign tx_near = tx_active && (tx_bit == 4'd9) && (tx_cnt == DIV_M2);

  // Transmitter: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= 1'b1;
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
    end else if (tx_load) begin
      tx        <= 1'b0;
      tx_sh     <= {1'b1, tx_byte};
      tx_active <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else if (tx_active) begin
      if (tx_cnt == DIV_M1) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_active <= 1'b0;
        end else begin
          tx_bit <= tx_bit + 4'd1;
          tx     <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  // ---------------- Command parser / Wishbone master ----------------
  state_t      state;
  logic [1:0]  byte_cnt;
  logic        is_wr;
  logic [31:0] adr_sh;
  logic [23:0] dat_sh;
  logic [23:0] resp_buf;
  logic [1:0]  resp_left;
  logic [15:0] tmo_cnt;

  assign busy = (state != S_IDLE);

  // Parser FSM: collects fields, runs the bus cycle, queues response bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      is_wr     <= 1'b0;
      adr_sh    <= '0;
      dat_sh    <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
      tmo_cnt   <= '0;
      tx_load   <= 1'b0;
      tx_byte   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      tx_load <= 1'b0;
      if (frame_err && (state == S_IDLE || state == S_ADDR || state == S_DATA)) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (byte_valid) begin
              byte_cnt <= '0;
              if (rx_sh == 8'h57 || rx_sh == 8'h52) begin
                is_wr <= (rx_sh == 8'h57);
                state <= S_ADDR;
              end else begin
                tx_load   <= 1'b1;
                tx_byte   <= 8'h3F;
                resp_left <= '0;
                state     <= S_RESP;
              end
            end
          end
          S_ADDR: begin
            if (byte_valid) begin
              adr_sh   <= {adr_sh[23:0], rx_sh};
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                if (is_wr) begin
                  state <= S_DATA;
                end else begin
                  wbm_adr_o <= {adr_sh[23:0], rx_sh};
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= 4'hF;
                  tmo_cnt   <= '0;
                  state     <= S_WB;
                end
              end
            end
          end
          S_DATA: begin
            if (byte_valid) begin
              dat_sh   <= {dat_sh[15:0], rx_sh};
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                wbm_adr_o <= adr_sh;
                wbm_dat_o <= {dat_sh, rx_sh};
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= 1'b1;
                wbm_sel_o <= 4'hF;
                tmo_cnt   <= '0;
                state     <= S_WB;
              end
            end
          end
          S_WB: begin
            // Ack is tested first so it wins on the terminal timeout cycle
            if (wbm_ack_i || tmo_cnt == TMO_M1) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_we_o  <= 1'b0;
              wbm_sel_o <= '0;
              tx_load   <= 1'b1;
              state     <= S_RESP;
              if (!wbm_ack_i) begin
                tx_byte   <= 8'h45;
                resp_left <= '0;
              end else if (is_wr) begin
                tx_byte   <= 8'h4B;
                resp_left <= '0;
              end else begin
                tx_byte   <= wbm_dat_i[31:24];
                resp_buf  <= wbm_dat_i[23:0];
                resp_left <= 2'd3;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
          S_RESP: begin
            if (tx_near && resp_left != 2'd0) begin
              tx_load   <= 1'b1;
              tx_byte   <= resp_buf[23:16];
              resp_buf  <= {resp_buf[15:0], 8'h00};
              resp_left <= resp_left - 2'd1;
            end else if (tx_done && !tx_load && resp_left == 2'd0) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
